// File: rtl/ic_interfaces_defs.sv
// ---------------------------------------------------------------------------
// ic_interfaces_defs
// Shared definitions for the master-write arbiter slice: FSM state
// encodings, default requester count, word geometry and the byte-swap
// helper used on the output data path.
// No ports (package).
// ---------------------------------------------------------------------------
package ic_interfaces_defs;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    // Y, Cb, Cr Huffman streams
    localparam int NREQ_DEFAULT = 3;

    // Every requester word and every bus write is one 32-bit word
    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = 8 * WORD_BYTES;

    // Reverse the byte order of one word (byte 0 becomes byte 3)
    function automatic logic [WORD_BITS-1:0] swap_bytes(input logic [WORD_BITS-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/ic_mw_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// ic_mw_write_arbiter_if
// Bundles the per-requester word handshake and the master-write bus.
//   req_valid/req_data/req_last : requester words (requester i at [32i+31:32i])
//   req_ready                   : word accepted when valid & ready
//   mw_address/mw_write/mw_writedata : master-write bus driven by the arbiter
//   mw_waitrequest              : slave stall
// Modports:
//   master : the arbiter side (drives req_ready and the write bus)
//   slave  : the environment side (requesters plus the write slave)
// ---------------------------------------------------------------------------
interface ic_mw_write_arbiter_if
    import ic_interfaces_defs::*;
#(
    parameter int NREQ   = NREQ_DEFAULT,
    parameter int ADDR_W = 32
);

    logic [NREQ-1:0]           req_valid;
    logic [WORD_BITS*NREQ-1:0] req_data;
    logic [NREQ-1:0]           req_last;
    logic [NREQ-1:0]           req_ready;
    logic [ADDR_W-1:0]         mw_address;
    logic                      mw_write;
    logic [WORD_BITS-1:0]      mw_writedata;
    logic                      mw_waitrequest;

    modport master (
        input  req_valid, req_data, req_last, mw_waitrequest,
        output req_ready, mw_address, mw_write, mw_writedata
    );

    modport slave (
        output req_valid, req_data, req_last, mw_waitrequest,
        input  req_ready, mw_address, mw_write, mw_writedata
    );

endinterface

// File: rtl/ic_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ic_rr_arbiter
// Combinational round-robin grant. The search starts at the index after
// last_grant and wraps NREQ-1 -> 0, so holding last_grant at NREQ-1 makes
// requester 0 the highest priority.
//   req        : request vector
//   last_grant : index of the most recently granted requester
//   grant      : one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module ic_rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant
);

    logic found_s;
    int   idx_s;

    // Rotating priority search over all requesters in one pass
    always_comb begin
        grant   = {NREQ{1'b0}};
        found_s = 1'b0;
        idx_s   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx_s = (int'(last_grant) + off) % NREQ;
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/ic_mw_write_arbiter.sv
// ---------------------------------------------------------------------------
// ic_mw_write_arbiter
// Collects whole blocks from NREQ Huffman stream requesters in round-robin
// order and writes them as contiguous words on a master-write bus, starting
// at a configured base address, until the configured block count is done.
//   clk, reset_n    : clock and asynchronous active-low reset
//   cfg_start       : one-cycle start pulse (ignored unless idle)
//   cfg_base_addr   : first write address (word aligned)
//   cfg_num_blocks  : blocks to transfer before done
//   bus             : requester handshake + master-write bus (master side)
//   busy            : high from an accepted start until DONE
//   done            : one-cycle pulse when all blocks are written
// ---------------------------------------------------------------------------
module ic_mw_write_arbiter
    import ic_interfaces_defs::*;
#(
    parameter int NREQ      = NREQ_DEFAULT,
    parameter int ADDR_W    = 32,
    parameter int BYTE_SWAP = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [15:0]           cfg_num_blocks,
    ic_mw_write_arbiter_if.master bus,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e           state_r;
    arb_state_e           state_s;
    logic [IDX_W-1:0]     grant_idx_r;
    logic                 mw_write_r;
    logic [ADDR_W-1:0]    addr_r;
    logic [WORD_BITS-1:0] wdata_r;
    logic [15:0]          blocks_done_r;
    logic [15:0]          num_blocks_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 slot_free_s;
    logic                 wr_done_s;
    logic                 cfg_load_s;
    logic                 grant_load_s;
    logic                 accept_s;
    logic                 acc_last_s;
    logic [WORD_BITS-1:0] acc_data_s;
    logic [NREQ-1:0]      req_ready_s;
    logic [NREQ-1:0]      rr_grant_s;
    logic [IDX_W-1:0]     rr_idx_s;

    // The output register can take a new word when it is empty or when its
    // current word is leaving this cycle.
    assign wr_done_s   = mw_write_r & ~bus.mw_waitrequest;
    assign slot_free_s = ~mw_write_r | ~bus.mw_waitrequest;
    assign cfg_load_s  = (state_r == ST_IDLE) & cfg_start;

    ic_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (grant_idx_r),
        .grant      (rr_grant_s)
    );

    // One-hot grant to index; unused unless a grant is actually loaded
    always_comb begin
        rr_idx_s = grant_idx_r;
        for (int i = 0; i < NREQ; i++) begin
            if (rr_grant_s[i]) begin
                rr_idx_s = IDX_W'(i);
            end else begin
                rr_idx_s = rr_idx_s;
            end
        end
    end

    // Only the granted requester sees ready, and only while transferring
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (state_r == ST_XFER) begin
            req_ready_s[grant_idx_r] = slot_free_s;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    assign accept_s   = (state_r == ST_XFER) & bus.req_valid[grant_idx_r] & slot_free_s;
    assign acc_last_s = accept_s & bus.req_last[grant_idx_r];
    assign acc_data_s = bus.req_data[int'(grant_idx_r) * WORD_BITS +: WORD_BITS];

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state. ARB waits for the previous block's final write to
    // drain before either finishing or granting the next block.
    always_comb begin
        state_s      = state_r;
        grant_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (!slot_free_s) begin
                    state_s = ST_ARB;
                end else if (blocks_done_r == num_blocks_r) begin
                    state_s = ST_DONE;
                end else if (|bus.req_valid) begin
                    state_s      = ST_XFER;
                    grant_load_s = 1'b1;
                end else begin
                    state_s = ST_ARB;
                end
            end
            ST_XFER: begin
                if (acc_last_s) begin
                    state_s = ST_ARB;
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: grant pointer, output word register, address and block count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_idx_r   <= IDX_W'(NREQ - 1);
            mw_write_r    <= 1'b0;
            addr_r        <= {ADDR_W{1'b0}};
            wdata_r       <= {WORD_BITS{1'b0}};
            blocks_done_r <= 16'd0;
            num_blocks_r  <= 16'd0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            if (grant_load_s) begin
                grant_idx_r <= rr_idx_s;
            end

            if (accept_s) begin
                mw_write_r <= 1'b1;
                wdata_r    <= (BYTE_SWAP != 0) ? swap_bytes(acc_data_s) : acc_data_s;
            end else if (wr_done_s) begin
                mw_write_r <= 1'b0;
            end

            if (cfg_load_s) begin
                addr_r <= cfg_base_addr;
            end else if (wr_done_s) begin
                addr_r <= addr_r + ADDR_W'(WORD_BYTES);
            end

            if (cfg_load_s) begin
                num_blocks_r  <= cfg_num_blocks;
                blocks_done_r <= 16'd0;
            end else if (acc_last_s) begin
                blocks_done_r <= blocks_done_r + 16'd1;
            end

            busy_r <= (state_s == ST_ARB) || (state_s == ST_XFER);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign bus.req_ready    = req_ready_s;
    assign bus.mw_write     = mw_write_r;
    assign bus.mw_address   = addr_r;
    assign bus.mw_writedata = wdata_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule
